// File: rtl/mini_mips_pkg.sv
// mini_mips_pkg: shared Mini-MIPS constants and the writeback request type
package mini_mips_pkg;
  localparam int MM_ADDR_WIDTH = 5;
  localparam int MM_BUS_WIDTH = 32;
  localparam logic [MM_ADDR_WIDTH-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic                     valid;
    logic [MM_ADDR_WIDTH-1:0] addr;
    logic [MM_BUS_WIDTH-1:0]  data;
  } wb_req_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular FIFO exposing per-entry tags and valid bits
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int TAG_WIDTH = WIDTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic                            pop,
  input  logic [WIDTH-1:0]                din,
  output logic [WIDTH-1:0]                dout,
  output logic [CW-1:0]                   count,
  output logic                            full,
  output logic                            empty,
  output logic [DEPTH-1:0][TAG_WIDTH-1:0] tags,
  output logic [DEPTH-1:0]                valid
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  for (genvar g = 0; g < DEPTH; g++) begin : g_tag
    assign tags[g] = mem[g][WIDTH-1 -: TAG_WIDTH];
  end
  // storage is left unreset; valid bits alone say which slots are live
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  // pointers, occupancy and valid bits; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
        valid[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        valid[rd_ptr] <= 1'b0;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and buffered load writebacks onto one register-file port
module writeback_arbiter
  import mini_mips_pkg::*;
#(
  parameter int COUNT = 32,
  parameter int BUS_WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int ADDR_WIDTH = $clog2(COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [BUS_WIDTH-1:0]    a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [BUS_WIDTH-1:0]    b_data,
  input  logic [ADDR_WIDTH-1:0]   query_addr1,
  input  logic [ADDR_WIDTH-1:0]   query_addr2,
  output logic                    pending1,
  output logic                    pending2,
  output logic                    rf_wr_en,
  output logic [ADDR_WIDTH-1:0]   rf_write_addr,
  output logic [BUS_WIDTH-1:0]    rf_data,
  output logic [$clog2(DEPTH):0]  b_count
);
  localparam int WIDTH = ADDR_WIDTH + BUS_WIDTH;
  logic a_take, b_push, b_pop, fifo_full, fifo_empty, hit1, hit2;
  logic [WIDTH-1:0] head;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] q_addr;
  logic [DEPTH-1:0] q_vld;
  wb_req_t sel;
  assign a_take = a_valid && a_addr != ZERO_REG;
  assign b_ready = !fifo_full && !rst;
  assign b_push = b_valid && b_ready && b_addr != ZERO_REG;
  assign b_pop = !a_take && !fifo_empty;
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAG_WIDTH(ADDR_WIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(b_push),
    .pop(b_pop),
    .din({b_addr, b_data}),
    .dout(head),
    .count(b_count),
    .full(fifo_full),
    .empty(fifo_empty),
    .tags(q_addr),
    .valid(q_vld)
  );
  // A wins; otherwise the FIFO head, whose emptiness is registered so a same-cycle push cannot be popped
  always_comb begin
    sel.valid = a_take || b_pop;
    sel.addr = MM_ADDR_WIDTH'(a_take ? a_addr : head[WIDTH-1 -: ADDR_WIDTH]);
    sel.data = MM_BUS_WIDTH'(a_take ? a_data : head[BUS_WIDTH-1:0]);
  end
  // registered write port; address and data hold while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en <= 1'b0;
      rf_write_addr <= '0;
      rf_data <= '0;
    end else begin
      rf_wr_en <= sel.valid;
      if (sel.valid) begin
        rf_write_addr <= ADDR_WIDTH'(sel.addr);
        rf_data <= BUS_WIDTH'(sel.data);
      end
    end
  end
  // scoreboard compare; during reset only the live A request can flag a hazard
  always_comb begin
    hit1 = (a_valid && a_addr == query_addr1) || (!rst && rf_wr_en && rf_write_addr == query_addr1);
    hit2 = (a_valid && a_addr == query_addr2) || (!rst && rf_wr_en && rf_write_addr == query_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      hit1 = hit1 || (!rst && q_vld[i] && q_addr[i] == query_addr1);
      hit2 = hit2 || (!rst && q_vld[i] && q_addr[i] == query_addr2);
    end
  end
  assign pending1 = hit1 && query_addr1 != ZERO_REG;
  assign pending2 = hit2 && query_addr2 != ZERO_REG;
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges register writebacks from two producers onto the single write port of the Mini-MIPS register file. Source A (ALU) is accepted every cycle without backpressure. Source B (load and multi-cycle units) is buffered in a small FIFO with valid/ready handshake. A scoreboard output lets decode stall on registers with writes still in flight.

## Interface
- COUNT, 32, number of architectural registers
- BUS_WIDTH, 32, data width
- DEPTH, 4, source-B FIFO entries (power of two, ≥2)
- ADDR_WIDTH, $clog2(COUNT), localparam, register address width
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, synchronous and active-high
- a_valid  input  1  source-A write request; always accepted
- a_addr  input  ADDR_WIDTH  source-A destination register
- a_data  input  BUS_WIDTH  source-A result
- b_valid  input  1  source-B write request
- b_ready  output  1  source-B may transfer this cycle
- b_addr  input  ADDR_WIDTH  source-B destination register
- b_data  input  BUS_WIDTH  source-B result
- query_addr1, query_addr2  input  ADDR_WIDTH  decode's source-register addresses
- pending1, pending2  output  1  a write to the matching query address is in flight
- rf_wr_en  output  1  to register file wr_en
- rf_write_addr  output  ADDR_WIDTH  to register file write_addr
- rf_data  output  BUS_WIDTH  to register file data_in
- b_count  output  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- B transfers on b_valid && b_ready.
- b_ready = (b_count < DEPTH) && !rst. It depends on registered state only and never on b_valid or a_valid.
- A B transfer with b_addr == 0 completes the handshake, but the data is discarded and not enqueued.
- A request with a_addr == 0 is ignored. No write is issued.
- Selection each cycle, A has priority:
  - a_valid && a_addr != 0: A goes to the output stage.
  - Otherwise, FIFO non-empty: the head is popped and goes to the output stage.
  - Otherwise: the output stage is idle.
- A same-cycle B enqueue is never popped in that cycle. The minimum FIFO residence is 1 cycle.
- Simultaneous push and pop: occupancy is unchanged. Pointers wrap modulo DEPTH.
- Ordering:
  - B entries drain in arrival order.
  - A may overtake older B entries. Decode uses the pending flags to prevent register-address hazards.
- Output stage: registered rf_wr_en, rf_write_addr and rf_data. When idle, rf_wr_en = 0 and addr/data are held.
- pending_n = 1 when query_addr_n != 0 and it equals any of:
  - a_addr with a_valid,
  - any valid FIFO entry address,
  - rf_write_addr with rf_wr_en.
- pending_n is combinational.
- Reset:
  - rf_wr_en = 0, rf_write_addr = 0, rf_data = 0.
  - FIFO is emptied and b_count = 0. Reset mid-operation discards queued entries; no partial write is issued.
  - b_ready = 0 during rst and 1 in the first cycle after.
  - pending is driven only by a_valid while rst is held.

## Timing
- A request in cycle N: rf_wr_en is high in cycle N+1. The register file commits at the end of N+1, and the value is readable in N+2.
- B transfer in cycle N, FIFO otherwise empty, no A traffic:
  - Popped in N+1.
  - rf_wr_en high in N+2.
- Continuous A traffic stalls the FIFO indefinitely. B backpressures when full.
- Sustained throughput is one register write per cycle.
- Full FIFO with a pop in cycle N: b_count drops at N+1, and b_ready rises in N+1.

## Structure
- Shared package mini_mips_pkg holds ZERO_REG = 0 and the writeback request struct (valid, addr, data). ADDR_WIDTH derivation stays local.
- One sub-module, sync_fifo, with parameters DEPTH and WIDTH = ADDR_WIDTH + BUS_WIDTH.
  - Ports: clk, rst, push, pop, din, dout, count, full, empty.
  - It exposes its address array and valid bits for the scoreboard compare.
- The arbiter, output register and pending compare live in writeback_arbiter.

## Test plan
- Reset then idle:
  - During rst: rf_wr_en = 0, b_count = 0, b_ready = 0.
  - Cycle after rst: b_ready = 1.
- A only:
  - Stimulus: a_valid with addr 5, data 0xDEADBEEF in cycle N.
  - rf_wr_en = 1, rf_write_addr = 5, rf_data = 0xDEADBEEF in N+1.
  - pending1 = 1 for query 5 in N and N+1; 0 in N+2.
- B fill and drain:
  - Stimulus: 4 B transfers (addrs 1–4) while A is continuously valid to addr 7.
  - b_count = 4, b_ready = 0, and rf writes are only to reg 7.
  - Drop A: B writes to regs 1, 2, 3, 4 appear on consecutive cycles.
- Zero register:
  - Stimulus: A to addr 0, and a B transfer to addr 0.
  - rf_wr_en stays 0, b_count stays 0, pending for query 0 stays 0.
- Simultaneous push/pop at full:
  - Stimulus: pop a full FIFO with no A, then a B transfer in the next cycle.
  - b_count goes 4→3→3, and order is preserved across the pointer wrap.
- Reset mid-operation:
  - Stimulus: 3 entries queued, rst asserted for 1 cycle.
  - No further rf writes, b_count = 0, and all pending flags are 0 afterwards.
